mux_2to1_stream_arb: RTL

Two-input stream arbiter that decides which of two sources drives a 2:1 mux, then registers the selected beat onto one output channel. Sits directly upstream of the 2:1 case mux and owns the `selection` decision. It adds valid/ready handshaking, round-robin fairness and packet locking, so a multi-beat packet from one source is never interleaved with the other.

---
 rtl/mux_2to1_stream_arb.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mux_2to1_stream_arb.sv
// Two-source stream arbiter feeding a registered 2:1 mux.
// Round-robin choice between A and B while idle; once a multi-beat packet
// starts, the arbiter locks to that source until its last beat is accepted.
//
// Handshake: a beat moves on a channel in any cycle where its valid and ready
// are both high at the rising clock edge. Valid never waits on ready; ready
// may depend on valid. The output register accepts a new beat whenever it is
// empty or its current beat is leaving in the same cycle.
module mux_2to1_stream_arb #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_last,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_last,
  input  logic              b_valid,
  output logic              b_ready,
  output logic [DATA_W-1:0] y_data,
  output logic              y_last,
  output logic              y_valid,
  input  logic              y_ready,
  output logic              selection,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOCK_A = 2'd1,
    S_LOCK_B = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_pri;
  logic                w_next_pri;
  logic                w_grant_a;
  logic                w_grant_b;
  logic                w_can_take;
  logic                w_acc_a;
  logic                w_acc_b;
  logic [DATA_W-1:0]   r_y_data;
  logic                r_y_last;
  logic                r_y_valid;
  logic                r_sel;

  assign w_can_take = !r_y_valid || y_ready;

  // Readies are forced low while reset is held so nothing is taken during reset.
  assign a_ready = rst_n && w_can_take && w_grant_a;
  assign b_ready = rst_n && w_can_take && w_grant_b;
  assign w_acc_a = a_valid && a_ready;
  assign w_acc_b = b_valid && b_ready;

  assign y_data      = r_y_data;
  assign y_last      = r_y_last;
  assign y_valid     = r_y_valid;
  assign selection   = r_sel;
  assign o_dbg_state = r_state;

  // State and priority registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pri   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_pri   <= w_next_pri;
    end
  end

  // Next state: only an accepted beat moves the FSM or the priority.
  always_comb begin
    w_next_state = r_state;
    w_next_pri   = r_pri;
    if (w_acc_a) begin
      if (a_last) begin
        w_next_state = S_IDLE;
        w_next_pri   = 1'b1;
      end else begin
        w_next_state = S_LOCK_A;
      end
    end else if (w_acc_b) begin
      if (b_last) begin
        w_next_state = S_IDLE;
        w_next_pri   = 1'b0;
      end else begin
        w_next_state = S_LOCK_B;
      end
    end
  end

  // Grant decode: round-robin in idle, exclusive to the owner while locked.
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_grant_a = a_valid && (!b_valid || !r_pri);
        w_grant_b = b_valid && (!a_valid ||  r_pri);
      end
      S_LOCK_A: w_grant_a = 1'b1;
      S_LOCK_B: w_grant_b = 1'b1;
      default: begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
      end
    endcase
  end

  // Output register: load on accept, drain when the held beat is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_data  <= '0;
      r_y_last  <= 1'b0;
      r_y_valid <= 1'b0;
      r_sel     <= 1'b0;
    end else if (w_acc_a) begin
      r_y_data  <= a_data;
      r_y_last  <= a_last;
      r_y_valid <= 1'b1;
      r_sel     <= 1'b0;
    end else if (w_acc_b) begin
      r_y_data  <= b_data;
      r_y_last  <= b_last;
      r_y_valid <= 1'b1;
      r_sel     <= 1'b1;
    end else if (r_y_valid && y_ready) begin
      r_y_valid <= 1'b0;
    end
  end

endmodule
